// File: rtl/rv_pkg.sv
// rv_pkg: shared constants and types for the register-file write-port block.
// Holds register-file geometry, instruction field positions and the
// starvation-FSM state encoding. No ports.
package rv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam int RD_LSB  = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } starve_state_t;

   function automatic logic [REG_ADDR_W-1:0] reg_field(input logic [XLEN-1:0] inst,
                                                       input int lsb);
      return inst[lsb +: REG_ADDR_W];
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits for outstanding long-latency writes.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_set_en/i_set_idx  mark a register busy (index 0 ignored)
//   i_clr_en/i_clr_idx  release a register
//   i_rd_a_idx/o_rd_a_busy, i_rd_b_idx/o_rd_b_busy  hazard lookups (x0 never busy)
//   o_busy_vec          full busy vector
module rf_scoreboard
   import rv_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_set_en,
   input  logic [REG_ADDR_W-1:0] i_set_idx,
   input  logic                  i_clr_en,
   input  logic [REG_ADDR_W-1:0] i_clr_idx,
   input  logic [REG_ADDR_W-1:0] i_rd_a_idx,
   input  logic [REG_ADDR_W-1:0] i_rd_b_idx,
   output logic                  o_rd_a_busy,
   output logic                  o_rd_b_busy,
   output logic [NUM_REGS-1:0]   o_busy_vec
);

   logic [NUM_REGS-1:0] r_busy;

   // A set and a clear never target the same register: an issue to a busy rd
   // stalls, so the set is ordered last only as a tie-break.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= '0;
      end else begin
         if (i_clr_en) r_busy[i_clr_idx] <= 1'b0;
         if (i_set_en && (i_set_idx != '0)) r_busy[i_set_idx] <= 1'b1;
      end
   end

   assign o_rd_a_busy = (i_rd_a_idx != '0) & r_busy[i_rd_a_idx];
   assign o_rd_b_busy = (i_rd_b_idx != '0) & r_busy[i_rd_b_idx];
   assign o_busy_vec  = r_busy;

endmodule

// File: rtl/rf_wport_sched.sv
// rf_wport_sched: owns the register-file write port. Arbitrates between the
// pipeline writeback and the long-latency unit (pipeline wins), tracks busy
// registers of outstanding long ops and stalls issue in X on hazards, a full
// long-op budget, or while draining a starved long-unit result.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   iss_valid/iss_inst/iss_long      instruction in X; iss_stall holds it
//   wb_valid/wb_rd/wb_data           pipeline writeback
//   lu_valid/lu_rd/lu_data/lu_ready  long-unit result handshake
//   rf_wen/rf_rd/rf_wdata            registered register-file write
// Optional (macro RF_WPORT_PERF_EN): perf_stall_cnt, perf_drain_cnt.
//
// state    | meaning
// ST_IDLE  | no long result waiting on the port
// ST_WAIT  | long result denied, counting consecutive denials
// ST_DRAIN | starvation limit hit, issue forced to stall until accepted
module rf_wport_sched
   import rv_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int STARVE_LIMIT    = 8
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  iss_valid,
   input  logic [XLEN-1:0]       iss_inst,
   input  logic                  iss_long,
   output logic                  iss_stall,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [XLEN-1:0]       wb_data,
   input  logic                  lu_valid,
   input  logic [REG_ADDR_W-1:0] lu_rd,
   input  logic [XLEN-1:0]       lu_data,
   output logic                  lu_ready,
   output logic                  rf_wen,
   output logic [REG_ADDR_W-1:0] rf_rd,
   output logic [XLEN-1:0]       rf_wdata
`ifdef RF_WPORT_PERF_EN
   ,
   output logic [31:0]           perf_stall_cnt,
   output logic [15:0]           perf_drain_cnt
`endif
);

   localparam int OUT_W = 4;

   logic [REG_ADDR_W-1:0] w_rs1, w_rs2, w_rd;
   logic                  w_wb_win, w_lu_hs, w_long_issue;
   logic                  w_rs1_busy, w_rs2_busy, w_hazard, w_full;
   logic [NUM_REGS-1:0]   w_busy_vec;
   logic [7:0]            w_cnt_inc;
   logic                  w_enter_drain;

   logic                  r_rf_wen, r_rf_from_lu;
   logic [REG_ADDR_W-1:0] r_rf_rd;
   logic [XLEN-1:0]       r_rf_wdata;
   logic [OUT_W-1:0]      r_outstanding;
   starve_state_t         r_state;
   logic [7:0]            r_starve_cnt;
   logic                  r_force_drain;

   assign w_rs1 = reg_field(iss_inst, RS1_LSB);
   assign w_rs2 = reg_field(iss_inst, RS2_LSB);
   assign w_rd  = reg_field(iss_inst, RD_LSB);

   assign w_wb_win = wb_valid & (wb_rd != '0);
   assign lu_ready = lu_valid & ~w_wb_win;
   assign w_lu_hs  = lu_ready;

   assign w_hazard  = w_rs1_busy | w_rs2_busy | ((w_rd != '0) & w_busy_vec[w_rd]);
   assign w_full    = iss_long & (r_outstanding == OUT_W'(MAX_OUTSTANDING));
   assign iss_stall = iss_valid & (w_hazard | w_full | r_force_drain);
   assign w_long_issue = iss_valid & iss_long & ~iss_stall;

   // Only long-unit writes release busy bits; the clear lands one cycle after
   // the port write so a dependent sees the value from the register file.
   rf_scoreboard u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .i_set_en    (w_long_issue),
      .i_set_idx   (w_rd),
      .i_clr_en    (r_rf_wen & r_rf_from_lu),
      .i_clr_idx   (r_rf_rd),
      .i_rd_a_idx  (w_rs1),
      .i_rd_b_idx  (w_rs2),
      .o_rd_a_busy (w_rs1_busy),
      .o_rd_b_busy (w_rs2_busy),
      .o_busy_vec  (w_busy_vec)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rf_wen     <= 1'b0;
         r_rf_from_lu <= 1'b0;
         r_rf_rd      <= '0;
         r_rf_wdata   <= '0;
      end else if (w_wb_win) begin
         r_rf_wen     <= 1'b1;
         r_rf_from_lu <= 1'b0;
         r_rf_rd      <= wb_rd;
         r_rf_wdata   <= wb_data;
      end else if (lu_ready && (lu_rd != '0)) begin
         r_rf_wen     <= 1'b1;
         r_rf_from_lu <= 1'b1;
         r_rf_rd      <= lu_rd;
         r_rf_wdata   <= lu_data;
      end else begin
         r_rf_wen     <= 1'b0;
         r_rf_from_lu <= 1'b0;
      end
   end

   assign rf_wen   = r_rf_wen;
   assign rf_rd    = r_rf_rd;
   assign rf_wdata = r_rf_wdata;

   // Saturating guards keep the counter from wrapping on a misbehaving unit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_outstanding <= '0;
      end else begin
         case ({w_long_issue, w_lu_hs})
            2'b10:   if (r_outstanding != '1) r_outstanding <= r_outstanding + 1'b1;
            2'b01:   if (r_outstanding != '0) r_outstanding <= r_outstanding - 1'b1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   // The count includes the current denial; in IDLE the count is zero, so
   // the first denial counts as one and a limit of 1 drains immediately.
   assign w_cnt_inc     = r_starve_cnt + 8'd1;
   assign w_enter_drain = (r_state != ST_DRAIN) & lu_valid & ~lu_ready
                          & (w_cnt_inc >= 8'(STARVE_LIMIT));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_starve_cnt  <= '0;
         r_force_drain <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_WAIT: begin
               if (!lu_valid || lu_ready) begin
                  r_state      <= ST_IDLE;
                  r_starve_cnt <= '0;
               end else if (w_enter_drain) begin
                  r_state       <= ST_DRAIN;
                  r_starve_cnt  <= w_cnt_inc;
                  r_force_drain <= 1'b1;
               end else begin
                  r_state      <= ST_WAIT;
                  r_starve_cnt <= w_cnt_inc;
               end
            end
            ST_DRAIN: begin
               if (lu_ready) begin
                  r_state       <= ST_IDLE;
                  r_starve_cnt  <= '0;
                  r_force_drain <= 1'b0;
               end
            end
            default: begin
               r_state       <= ST_IDLE;
               r_starve_cnt  <= '0;
               r_force_drain <= 1'b0;
            end
         endcase
      end
   end

`ifdef RF_WPORT_PERF_EN
   logic [31:0] r_perf_stall;
   logic [15:0] r_perf_drain;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_stall <= '0;
         r_perf_drain <= '0;
      end else begin
         if (iss_stall && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
         if (w_enter_drain && (r_perf_drain != '1)) r_perf_drain <= r_perf_drain + 16'd1;
      end
   end

   assign perf_stall_cnt = r_perf_stall;
   assign perf_drain_cnt = r_perf_drain;
`endif

endmodule

// File: tb/tb_rf_wport_sched.sv
module tb_rf_wport_sched;

   localparam int MAX_OUT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        iss_valid, iss_long, iss_stall;
   logic [31:0] iss_inst;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        lu_valid, lu_ready;
   logic [4:0]  lu_rd;
   logic [31:0] lu_data;
   logic        rf_wen;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;
`ifdef RF_WPORT_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [15:0] perf_drain_cnt;
`endif

   always #5 clk = ~clk;

   rf_wport_sched #(.MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .iss_valid (iss_valid),
      .iss_inst  (iss_inst),
      .iss_long  (iss_long),
      .iss_stall (iss_stall),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .lu_valid  (lu_valid),
      .lu_rd     (lu_rd),
      .lu_data   (lu_data),
      .lu_ready  (lu_ready),
      .rf_wen    (rf_wen),
      .rf_rd     (rf_rd),
      .rf_wdata  (rf_wdata)
`ifdef RF_WPORT_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_drain_cnt (perf_drain_cnt)
`endif
   );

   int n_err = 0;
   int n_chk = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   typedef struct packed {
      logic        wen;
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  model_out;

   function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b0, rd, 7'h33};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Write-port scoreboard: each cycle's expected port write is queued from the
   // inputs and compared against rf_* one cycle later.
   always @(negedge clk) begin
      wr_t e;
      wr_t n;
      logic pipe_win;
      if (exp_q.size() == 0) begin
         chk("wq_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk("rf_wen", {31'b0, rf_wen}, {31'b0, e.wen});
         if (e.wen) begin
            chk("rf_rd", {27'b0, rf_rd}, {27'b0, e.rd});
            chk("rf_wdata", rf_wdata, e.data);
         end
      end
      pipe_win = wb_valid && (wb_rd != 5'd0);
      chk("lu_ready", {31'b0, lu_ready}, {31'b0, lu_valid && !pipe_win});
      n = '0;
      if (!rst) begin
         if (pipe_win) n = {1'b1, wb_rd, wb_data};
         else if (lu_valid && (lu_rd != 5'd0)) n = {1'b1, lu_rd, lu_data};
      end
      exp_q.push_back(n);
      if (rst) begin
         model_out = 0;
      end else begin
         if (iss_valid && iss_long && !iss_stall) model_out++;
         if (lu_valid && lu_ready) model_out--;
         if (model_out < 0 || model_out > MAX_OUT) begin
            chk("outstanding_range", 32'(model_out), 32'(MAX_OUT));
            model_out = (model_out < 0) ? 0 : MAX_OUT;
         end
      end
   end

   initial begin
      int ret[4] = '{2, 3, 4, 8};
      int lng[4] = '{9, 15, 16, 17};
      rst = 1'b1;
      iss_valid = 0; iss_long = 0; iss_inst = '0;
      wb_valid = 0; wb_rd = '0; wb_data = '0;
      lu_valid = 0; lu_rd = '0; lu_data = '0;
      model_out = 0;
      exp_q.push_back('0);

      repeat (2) step();
      rst = 1'b0;
      #1;
      chk("rst_stall", {31'b0, iss_stall}, 32'd0);
      chk("rst_rf_wen", {31'b0, rf_wen}, 32'd0);
      chk("rst_rf_rd", {27'b0, rf_rd}, 32'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);

      // RAW on a long result
      iss_valid = 1; iss_long = 1; iss_inst = mk(5, 0, 0);
      #1 chk("raw_long_issue", {31'b0, iss_stall}, 32'd0);
      step(); iss_long = 0; iss_inst = mk(6, 5, 0);
      #1 chk("raw_stall0", {31'b0, iss_stall}, 32'd1);
      step();
      #1 chk("raw_stall1", {31'b0, iss_stall}, 32'd1);
      step(); lu_valid = 1; lu_rd = 5; lu_data = 32'h55;
      #1 chk("raw_lu_ready", {31'b0, lu_ready}, 32'd1);
      chk("raw_stall2", {31'b0, iss_stall}, 32'd1);
      step(); lu_valid = 0;
      #1 chk("raw_stall_wen", {31'b0, iss_stall}, 32'd1);
      chk("raw_rf_rd", {27'b0, rf_rd}, 32'd5);
      step();
      #1 chk("raw_release", {31'b0, iss_stall}, 32'd0);
      step(); iss_valid = 0;

      // Arbitration: pipeline beats long unit
      iss_valid = 1; iss_long = 1; iss_inst = mk(7, 0, 0);
      #1 chk("arb_long_issue", {31'b0, iss_stall}, 32'd0);
      step(); iss_valid = 0; iss_long = 0;
      wb_valid = 1; wb_rd = 3; wb_data = 32'hAA;
      lu_valid = 1; lu_rd = 7; lu_data = 32'hBB;
      #1 chk("arb_lu_denied", {31'b0, lu_ready}, 32'd0);
      step(); wb_valid = 0;
      #1 chk("arb_rf_rd_wb", {27'b0, rf_rd}, 32'd3);
      chk("arb_rf_wdata_wb", rf_wdata, 32'hAA);
      chk("arb_lu_granted", {31'b0, lu_ready}, 32'd1);
      step(); lu_valid = 0;
      #1 chk("arb_rf_rd_lu", {27'b0, rf_rd}, 32'd7);
      chk("arb_rf_wdata_lu", rf_wdata, 32'hBB);
      step();

      // Outstanding limit
      iss_valid = 1; iss_long = 1;
      for (int i = 1; i <= 4; i++) begin
         iss_inst = mk(5'(i), 0, 0);
         #1 chk("full_issue", {31'b0, iss_stall}, 32'd0);
         step();
      end
      iss_inst = mk(8, 0, 0);
      #1 chk("full_stall", {31'b0, iss_stall}, 32'd1);
      iss_long = 0; iss_inst = mk(10, 11, 12);
      #1 chk("full_short_ok", {31'b0, iss_stall}, 32'd0);
      iss_long = 1; iss_inst = mk(8, 0, 0);
      lu_valid = 1; lu_rd = 1; lu_data = 32'h101;
      #1 chk("full_hs", {31'b0, lu_ready}, 32'd1);
      chk("full_stall_hs", {31'b0, iss_stall}, 32'd1);
      step(); lu_valid = 0;
      #1 chk("full_release", {31'b0, iss_stall}, 32'd0);
      step(); iss_valid = 0; iss_long = 0;
      for (int i = 0; i < 4; i++) begin
         lu_valid = 1; lu_rd = 5'(ret[i]); lu_data = 32'h100 + 32'(ret[i]);
         step();
      end
      lu_valid = 0;
      step(); step();

      // Starvation -> DRAIN
      iss_valid = 1; iss_long = 1; iss_inst = mk(12, 0, 0);
      #1 chk("starve_long_issue", {31'b0, iss_stall}, 32'd0);
      step(); iss_long = 0; iss_inst = mk(14, 1, 2);
      lu_valid = 1; lu_rd = 12; lu_data = 32'hC0C0;
      wb_valid = 1; wb_rd = 13;
      for (int k = 1; k <= 8; k++) begin
         wb_data = 32'(k);
         #1 chk("starve_wait_stall", {31'b0, iss_stall}, 32'd0);
         step();
      end
      wb_data = 32'd9;
      #1 chk("starve_drain_stall", {31'b0, iss_stall}, 32'd1);
      step(); wb_valid = 0;
      #1 chk("starve_bubble_ready", {31'b0, lu_ready}, 32'd1);
      chk("starve_bubble_stall", {31'b0, iss_stall}, 32'd1);
      step(); lu_valid = 0;
      #1 chk("starve_idle", {31'b0, iss_stall}, 32'd0);
      step(); iss_valid = 0;
      step(); step();

      // rd = 0 on both issue and result
      iss_valid = 1; iss_long = 1; iss_inst = mk(0, 0, 0);
      #1 chk("rd0_issue", {31'b0, iss_stall}, 32'd0);
      step(); iss_valid = 0; iss_long = 0;
      lu_valid = 1; lu_rd = 0; lu_data = 32'h77;
      #1 chk("rd0_lu_ready", {31'b0, lu_ready}, 32'd1);
      step(); lu_valid = 0;
      #1 chk("rd0_no_wen", {31'b0, rf_wen}, 32'd0);
      step();
      iss_valid = 1; iss_long = 1;
      for (int i = 0; i < 4; i++) begin
         iss_inst = mk(5'(lng[i]), 0, 0);
         #1 chk("rd0_out_restored", {31'b0, iss_stall}, 32'd0);
         step();
      end
      iss_inst = mk(18, 0, 0);
      #1 chk("pre_rst_full", {31'b0, iss_stall}, 32'd1);
      iss_long = 0; iss_inst = mk(20, 9, 0);
      #1 chk("pre_rst_busy9", {31'b0, iss_stall}, 32'd1);

      // Reset mid-operation
      iss_valid = 0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1 chk("mid_rst_wen", {31'b0, rf_wen}, 32'd0);
      iss_valid = 1; iss_long = 0; iss_inst = mk(20, 9, 0);
      #1 chk("mid_rst_x9_reader", {31'b0, iss_stall}, 32'd0);
      step();
      iss_long = 1;
      for (int i = 0; i < 4; i++) begin
         iss_inst = mk(5'(lng[i]), 0, 0);
         #1 chk("mid_rst_out_zero", {31'b0, iss_stall}, 32'd0);
         step();
      end
      iss_inst = mk(18, 0, 0);
      #1 chk("mid_rst_full", {31'b0, iss_stall}, 32'd1);
      iss_valid = 0; iss_long = 0;
      step(); step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
